complex_result_unpacker: RTL and testbench

Consumer for the wide result bus of complex_matrix_mul. It sits on the multiplier's out_valid_o/out_ready_i handshake and captures one full result vector of SIZE complex values. It then streams the vector out one complex element per beat, with its index and a last flag, over a valid/ready interface. It keeps the wide result bus off downstream logic, such as writeback, result FIFOs or host readout.

---
 rtl/complex_result_unpacker.sv | 80 ++++++++
 tb/tb_complex_result_unpacker.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/complex_result_unpacker.sv
// complex_result_unpacker: captures one wide complex result vector and streams it
// out one element per beat with index, last flag and the captured FP status.
module complex_result_unpacker #(
    parameter int SIZE     = 16,
    parameter int WIDTH    = 64,
    parameter int STATUS_W = 5
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [2*SIZE*WIDTH-1:0]     result_i,
    input  logic [STATUS_W-1:0]         status_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [WIDTH-1:0]            out_real_o,
    output logic [WIDTH-1:0]            out_imag_o,
    output logic [$clog2(SIZE)-1:0]     out_idx_o,
    output logic                        out_last_o,
    output logic [STATUS_W-1:0]         out_status_o,
    output logic                        busy_o
);
    localparam int IW = $clog2(SIZE);

    typedef enum logic {IDLE, STREAM} state_e;

    state_e                       state_q, state_d;
    logic [IW-1:0]                idx_q, idx_d;
    logic [2*SIZE-1:0][WIDTH-1:0] buf_q, buf_d;
    logic [STATUS_W-1:0]          status_q, status_d;
    logic                         busy, last, cap;

    always_comb begin
        busy       = state_q == STREAM;
        last       = busy && idx_q == IW'(SIZE - 1);
        // Accepting on the last beat lets a new vector follow without a bubble.
        in_ready_o = !busy || (last && out_ready_i);
        cap        = in_valid_i && in_ready_o;
        state_d    = state_q;
        idx_d      = idx_q;
        buf_d      = buf_q;
        status_d   = status_q;
        if (flush_i) begin
            state_d = IDLE;
            idx_d   = '0;
        end else if (cap) begin
            state_d  = STREAM;
            idx_d    = '0;
            buf_d    = result_i;
            status_d = status_i;
        end else if (busy && out_ready_i) begin
            state_d = last ? IDLE : STREAM;
            idx_d   = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            buf_q    <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            buf_q    <= buf_d;
            status_q <= status_d;
        end
    end

    assign out_valid_o  = busy;
    assign busy_o       = busy;
    assign out_last_o   = last;
    assign out_idx_o    = idx_q;
    assign out_real_o   = buf_q[{idx_q, 1'b0}];
    assign out_imag_o   = buf_q[{idx_q, 1'b1}];
    assign out_status_o = status_q;

endmodule

// File: tb/tb_complex_result_unpacker.sv
// tb_complex_result_unpacker: directed + random stimulus, scoreboard of expected
// element beats pushed on each modelled capture and popped by a negedge monitor.
module tb_complex_result_unpacker;
    localparam int SIZE = 16;
    localparam int WIDTH = 64;
    localparam int SW = 5;
    localparam int IW = $clog2(SIZE);

    typedef struct {
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
        int               idx;
        logic             last;
        logic [SW-1:0]    st;
    } beat_t;

    logic                    clk_i = 0;
    logic                    rst_ni = 0;
    logic                    flush_i = 0;
    logic                    in_valid_i = 0;
    logic                    in_ready_o;
    logic [2*SIZE*WIDTH-1:0] result_i = '0;
    logic [SW-1:0]           status_i = '0;
    logic                    out_valid_o;
    logic                    out_ready_i = 0;
    logic [WIDTH-1:0]        out_real_o;
    logic [WIDTH-1:0]        out_imag_o;
    logic [IW-1:0]           out_idx_o;
    logic                    out_last_o;
    logic [SW-1:0]           out_status_o;
    logic                    busy_o;

    beat_t q[$];
    int    compared = 0;
    int    mismatched = 0;
    int    beats = 0;

    complex_result_unpacker #(.SIZE(SIZE), .WIDTH(WIDTH), .STATUS_W(SW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .result_i(result_i), .status_i(status_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_real_o(out_real_o), .out_imag_o(out_imag_o),
        .out_idx_o(out_idx_o), .out_last_o(out_last_o),
        .out_status_o(out_status_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: a captured vector is simply SIZE queued beats; flush or reset drops them.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            q.delete();
        end else begin
            automatic bit have = q.size() != 0;
            automatic bit exp_rdy = !have || (q.size() == 1 && out_ready_i);
            chk("out_valid", 64'(out_valid_o), 64'(have));
            chk("busy", 64'(busy_o), 64'(have));
            chk("in_ready", 64'(in_ready_o), 64'(exp_rdy));
            if (have && out_valid_o) begin
                chk("real", out_real_o, q[0].re);
                chk("imag", out_imag_o, q[0].im);
                chk("idx", 64'(out_idx_o), 64'(q[0].idx));
                chk("last", 64'(out_last_o), 64'(q[0].last));
                chk("status", 64'(out_status_o), 64'(q[0].st));
            end
            if (have && out_ready_i) begin
                void'(q.pop_front());
                beats++;
            end
            if (flush_i) q.delete();
            else if (in_valid_i && exp_rdy)
                for (int i = 0; i < SIZE; i++)
                    q.push_back('{result_i[2*i*WIDTH +: WIDTH], result_i[(2*i+1)*WIDTH +: WIDTH],
                                  i, i == SIZE - 1, status_i});
        end
    end

    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic rand_vec();
        for (int i = 0; i < 2 * SIZE; i++) result_i[i*WIDTH +: WIDTH] = {$urandom, $urandom};
    endtask

    initial begin
        int b0;
        repeat (2) cycle();
        chk("rst_valid", 64'(out_valid_o), 0);
        chk("rst_busy", 64'(busy_o), 0);
        chk("rst_ready", 64'(in_ready_o), 1);
        chk("rst_real", out_real_o, 0);
        chk("rst_imag", out_imag_o, 0);
        chk("rst_idx", 64'(out_idx_o), 0);
        chk("rst_last", 64'(out_last_o), 0);
        chk("rst_status", 64'(out_status_o), 0);
        rst_ni = 1;
        cycle();

        // Single vector with +i/-i reals, then input bus goes all-ones while held
        for (int i = 0; i < SIZE; i++) begin
            result_i[2*i*WIDTH +: WIDTH]     = $realtobits(real'(i));
            result_i[(2*i+1)*WIDTH +: WIDTH] = $realtobits(-real'(i));
        end
        status_i = 5'b10100;
        out_ready_i = 1;
        in_valid_i = 1;
        cycle();
        in_valid_i = 0;
        result_i = '1;
        repeat (20) cycle();

        // Backpressure with status NX
        rand_vec();
        status_i = 5'b00001;
        in_valid_i = 1;
        cycle();
        in_valid_i = 0;
        for (int c = 0; c < 80; c++) begin
            out_ready_i = c < 4 ? (c == 0 || c == 3) : $urandom_range(0, 1) == 1;
            cycle();
        end
        out_ready_i = 1;
        repeat (20) cycle();

        // Back-to-back: B captured on A's last beat
        rand_vec();
        status_i = 5'b00010;
        in_valid_i = 1;
        cycle();
        b0 = beats;
        rand_vec();
        status_i = 5'b01000;
        repeat (16) cycle();
        in_valid_i = 0;
        repeat (16) cycle();
        chk("b2b_beats", 64'(beats - b0), 32);
        repeat (4) cycle();

        // Flush at idx 5 with a competing input vector
        rand_vec();
        in_valid_i = 1;
        cycle();
        in_valid_i = 0;
        repeat (5) cycle();
        rand_vec();
        flush_i = 1;
        in_valid_i = 1;
        cycle();
        flush_i = 0;
        in_valid_i = 0;
        chk("flush_valid", 64'(out_valid_o), 0);
        chk("flush_busy", 64'(busy_o), 0);
        rand_vec();
        in_valid_i = 1;
        cycle();
        in_valid_i = 0;
        repeat (20) cycle();

        // Asynchronous reset mid-stream at idx 9
        rand_vec();
        status_i = 5'b11111;
        in_valid_i = 1;
        cycle();
        in_valid_i = 0;
        repeat (9) cycle();
        #2;
        rst_ni = 0;
        #1;
        chk("arst_valid", 64'(out_valid_o), 0);
        chk("arst_idx", 64'(out_idx_o), 0);
        chk("arst_ready", 64'(in_ready_o), 1);
        chk("arst_status", 64'(out_status_o), 0);
        cycle();
        #2;
        rst_ni = 1;
        cycle();

        // Random traffic with occasional flushes
        for (int c = 0; c < 600; c++) begin
            rand_vec();
            status_i = SW'($urandom);
            in_valid_i = $urandom_range(0, 3) == 0;
            out_ready_i = $urandom_range(0, 9) < 7;
            flush_i = $urandom_range(0, 49) == 0;
            cycle();
        end
        in_valid_i = 0;
        flush_i = 0;
        out_ready_i = 1;
        repeat (20) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
